// File: rtl/piso_serializer_pkg.sv
// +------------------------------------------------------------------+
// | piso_serializer_pkg: shared word size and serializer state codes  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package piso_serializer_pkg;

  // Shared with the upstream parallel register so both agree on word size
  localparam int c_DEFAULT_WIDTH = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/piso_serializer_bit_counter.sv
// +------------------------------------------------------------------+
// | piso_serializer_bit_counter: mod-WIDTH up-counter with clear      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module piso_serializer_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last = (cnt_q == CW'(WIDTH - 1));
  assign cnt  = cnt_q;

  // Clear wins over enable so a reload always restarts at bit 0
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// +------------------------------------------------------------------+
// | piso_serializer: parallel-in serial-out with load handshake,     |
// | pause and registered frame markers. Rev 1.0                       |
// +------------------------------------------------------------------+
`default_nettype none

module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = c_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic             PAUSE,
  output logic             SOUT,
  output logic             SOUT_VALID,
  output logic             FRAME_START,
  output logic             FRAME_END,
  output logic             BUSY
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    w_cnt;
  logic             w_last;
  logic             w_busy;
  logic             w_accept;
  logic             w_bit;
  logic             sout_q, busy_q, fstart_q, fend_q;

  assign w_busy     = (state_q == ST_SHIFT);
  assign LOAD_READY = !PAUSE && ((state_q == ST_IDLE) || (w_busy && w_last));
  assign w_accept   = LOAD_VALID && LOAD_READY;

  piso_serializer_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (w_accept),
    .enable (w_busy && !PAUSE),
    .cnt    (w_cnt),
    .last   (w_last)
  );

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_bit = shreg_q[WIDTH-1];
    end else begin : g_lsb_first
      assign w_bit = shreg_q[0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    if (w_accept) begin
      state_d = ST_SHIFT;
      shreg_d = DIN;
    end else if (w_busy && !PAUSE) begin
      if (w_last) begin
        state_d = ST_IDLE;
      end else if (MSB_FIRST) begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end
    end
  end

  // Outputs are registered one edge behind the shifter so every flag lines up with SOUT
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      sout_q   <= 1'b0;
      busy_q   <= 1'b0;
      fstart_q <= 1'b0;
      fend_q   <= 1'b0;
    end else if (!PAUSE) begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      sout_q   <= w_busy && w_bit;
      busy_q   <= w_busy;
      fstart_q <= w_busy && (w_cnt == '0);
      fend_q   <= w_busy && w_last;
    end
  end

  assign SOUT        = sout_q;
  assign SOUT_VALID  = busy_q;
  assign BUSY        = busy_q;
  assign FRAME_START = fstart_q;
  assign FRAME_END   = fend_q;

endmodule

`default_nettype wire
